sample_frame_writer: RTL
========================

# sample_frame_writer

Fabric-side writer for the 16-bit dual-port sample buffer that the HPS reads over its own port. Captures a triggered, optionally decimated frame of signed ADC samples into consecutive buffer words starting at word 0, driving the buffer's second slave port directly. Control inputs and status outputs connect to the HPS-visible PIO, so software can arm, poll, and read back a frame.

## Interface

- ADDR_W, 9: buffer word-address width; capacity is 2^ADDR_W words.
- DATA_W, 16: sample and buffer word width.

- clk_clk  in  1  system clock; same clock as the buffer slave port.
- reset_reset_n  in  1  reset, synchronous, active-low.
- arm  in  1  level input; its rising edge starts a frame.
- abort  in  1  level input; while high, forces IDLE.
- trig_mode  in  1  0 = immediate start, 1 = rising threshold crossing.
- trig_level  in  DATA_W  signed trigger threshold.
- decim  in  8  keep 1 of every decim+1 accepted samples.
- frame_len  in  ADDR_W+1  samples per frame. 0 or values above 2^ADDR_W mean 2^ADDR_W.
- sample_valid  in  1  one-cycle qualifier for sample_data.
- sample_data  in  DATA_W  signed sample.
- mem_address  out  ADDR_W  buffer word address.
- mem_chipselect  out  1  buffer select; equal to mem_write.
- mem_clken  out  1  buffer clock enable.
- mem_write  out  1  one-cycle write strobe.
- mem_writedata  out  DATA_W  sample being written.
- mem_byteenable  out  DATA_W/8  all ones.
- status_busy  out  1  high in WAIT_TRIG or CAPTURE.
- status_done  out  1  frame complete.
- status_count  out  ADDR_W+1  number of words written in the current or last frame.

## Operation

- States: IDLE, WAIT_TRIG, CAPTURE, DONE. After reset the block is in IDLE.
- A rising edge on arm is detected against a registered copy of arm; that copy resets to 1, so arm held high through reset does not start a frame.
- Arm edge in IDLE or DONE:
  - latch frame_len, decim, trig_mode and trig_level;
  - clear status_count, the address, the decimation counter and prev_valid;
  - go to CAPTURE if trig_mode = 0, otherwise to WAIT_TRIG.
- Arm edges seen in WAIT_TRIG or CAPTURE are ignored.
- WAIT_TRIG, on each sample_valid:
  - register the sample as prev and set prev_valid;
  - trigger when prev_valid = 1, prev < trig_level and sample_data >= trig_level (signed compare);
  - the triggering sample is written as word 0, the decimation counter restarts from it, and the state becomes CAPTURE.
  - The first sample after arm can never trigger.
- CAPTURE, on each sample_valid:
  - if the decimation counter is 0, write the sample and reload the counter with the latched decim; otherwise decrement the counter and write nothing.
  - In immediate mode the first valid sample is always written.
- Write: mem_address = status_count[ADDR_W-1:0]. status_count increments in the same cycle the write is on the bus.
- When status_count reaches the latched length, go to DONE and set status_done = 1. Address 2^ADDR_W is never driven; the address does not wrap within a frame.
- DONE holds until the next arm edge, abort, or reset. status_done clears on arm edge or abort.
- abort = 1 from any state goes to IDLE; the pending or coincident sample is not written. status_count holds its value. Abort takes priority over a simultaneous arm edge.
- mem_clken = 1 whenever reset_reset_n = 1.

## Timing

- All outputs are registered.
- Reset values:
  - mem_address 0, mem_write 0, mem_chipselect 0, mem_writedata 0, mem_clken 0;
  - mem_byteenable all ones;
  - status_busy 0, status_done 0, status_count 0.
- Latency: a sample accepted at cycle t appears at cycle t+1 as mem_write = 1 with its address and data. Each write is a single cycle.
- Throughput is one write per clock; back-to-back sample_valid is supported with no loss.
- The arm edge is registered at t. status_busy = 1 from t+1.
- The final write is at cycle u. At u, status_done = 1, status_busy = 0 and status_count = length.
- Reset asserted mid-frame: all outputs take their reset values on the next edge. No partial write is issued after the reset edge.

## Test plan

- Immediate mode, frame_len = 4, decim = 0, samples 10, 11, 12, 13, 14 back-to-back:
  - required: writes to addresses 0..3 with 10..13, each one cycle after its sample;
  - status_done rises with the write of 13; sample 14 is not written; status_count = 4.
- Trigger mode, trig_level = 100, samples 120, 50, 99, 100, 200, frame_len = 2:
  - required: 120 does not trigger (no prev);
  - the trigger fires on 100, so the writes are 100 @0 and 200 @1.
- decim = 2, frame_len = 3, samples 1..9:
  - required: the writes are 1, 4, 7 at addresses 0, 1, 2.
- frame_len = 0:
  - required: 512 writes, last address 511, status_count = 512, no write to address 0 after the last one.
- Abort after 5 of 8 writes, coincident with sample_valid:
  - required: the sample is not written, state is IDLE, status_count = 5, status_busy = 0, status_done = 0.
- Arm pulse during CAPTURE, then reset asserted mid-frame:
  - required: the arm pulse is ignored;
  - after the reset edge, mem_write = 0 and status_count = 0;
  - arm held high through reset release does not start a frame.

Source files
------------

// File: rtl/sample_frame_writer.sv
// sample_frame_writer
//   Captures a triggered, optionally decimated frame of signed ADC samples
//   into consecutive words of a dual-port buffer, starting at word 0.
//   Control comes from HPS-visible PIO; status lets software poll the frame.
//
// Ports
//   clk_clk, reset_reset_n      clock, synchronous active-low reset
//   arm, abort                  rising edge of arm starts a frame; abort forces IDLE
//   trig_mode, trig_level       0 = immediate, 1 = rising crossing of trig_level
//   decim                       keep 1 of every decim+1 accepted samples
//   frame_len                   samples per frame (0 or > 2^ADDR_W means 2^ADDR_W)
//   sample_valid, sample_data   sample stream
//   mem_*                       buffer slave port (one-cycle writes)
//   status_busy/done/count      frame status
module sample_frame_writer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                trig_mode,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic [7:0]          decim,
    input  logic [ADDR_W:0]     frame_len,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_data,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                status_busy,
    output logic                status_done,
    output logic [ADDR_W:0]     status_count
);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t             state;
    logic               arm_q;
    logic [ADDR_W:0]    len_q;
    logic [7:0]         decim_q;
    logic [7:0]         dcnt;
    logic [DATA_W-1:0]  trig_level_q;
    logic [DATA_W-1:0]  prev;
    logic               prev_valid;

    logic               arm_edge;
    logic [ADDR_W:0]    len_norm;
    logic [ADDR_W:0]    count_inc;
    logic               last_word;
    logic               trig_hit;

    always_comb begin
        arm_edge  = arm & ~arm_q;
        len_norm  = ((frame_len == '0) || (frame_len > FULL_LEN)) ? FULL_LEN : frame_len;
        count_inc = status_count + (ADDR_W+1)'(1);
        last_word = (count_inc == len_q);
        trig_hit  = prev_valid
                    && ($signed(prev) < $signed(trig_level_q))
                    && ($signed(sample_data) >= $signed(trig_level_q));
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state          <= IDLE;
            arm_q          <= 1'b1;   // arm held through reset must not look like an edge
            len_q          <= FULL_LEN;
            decim_q        <= '0;
            dcnt           <= '0;
            trig_level_q   <= '0;
            prev           <= '0;
            prev_valid     <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '1;
            status_busy    <= 1'b0;
            status_done    <= 1'b0;
            status_count   <= '0;
        end else begin
            arm_q          <= arm;
            mem_clken      <= 1'b1;
            mem_byteenable <= '1;
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;

            if (abort) begin
                state       <= IDLE;
                status_busy <= 1'b0;
                status_done <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (arm_edge) begin
                            len_q        <= len_norm;
                            decim_q      <= decim;
                            trig_level_q <= trig_level;
                            status_count <= '0;
                            mem_address  <= '0;
                            dcnt         <= '0;
                            prev_valid   <= 1'b0;
                            status_busy  <= 1'b1;
                            status_done  <= 1'b0;
                            // trigger mode is consumed here: it only selects the entry state
                            state        <= trig_mode ? WAIT_TRIG : CAPTURE;
                        end
                    end

                    WAIT_TRIG: begin
                        if (sample_valid) begin
                            prev       <= sample_data;
                            prev_valid <= 1'b1;
                            if (trig_hit) begin
                                mem_write      <= 1'b1;
                                mem_chipselect <= 1'b1;
                                mem_address    <= status_count[ADDR_W-1:0];
                                mem_writedata  <= sample_data;
                                status_count   <= count_inc;
                                dcnt           <= decim_q;
                                if (last_word) begin
                                    state       <= DONE;
                                    status_busy <= 1'b0;
                                    status_done <= 1'b1;
                                end else begin
                                    state <= CAPTURE;
                                end
                            end
                        end
                    end

                    CAPTURE: begin
                        if (sample_valid) begin
                            if (dcnt == '0) begin
                                mem_write      <= 1'b1;
                                mem_chipselect <= 1'b1;
                                mem_address    <= status_count[ADDR_W-1:0];
                                mem_writedata  <= sample_data;
                                status_count   <= count_inc;
                                dcnt           <= decim_q;
                                if (last_word) begin
                                    state       <= DONE;
                                    status_busy <= 1'b0;
                                    status_done <= 1'b1;
                                end
                            end else begin
                                dcnt <= dcnt - 8'd1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
